// File: rtl/min_of_four_stream_if.sv
// Streaming bundle for min_of_four_stream.
// Input side:  in_valid/in_data from the producer, in_ready back to it.
// Output side: out_valid/out_index/out_min to the consumer, out_ready back from it.
// Modports: slave = the min-of-four block, master = the producer/consumer (testbench).
interface min_of_four_stream_if #(
  parameter int unsigned WIDTH = 3
) ();
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [1:0]       out_index;
  logic [WIDTH-1:0] out_min;
  logic             out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_index,
    output out_min,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_index,
    input  out_min,
    output out_ready
  );
endinterface

// File: rtl/min_of_four_stream.sv
// Streaming minimum-of-four. Collects four unsigned samples (positions 0..3) over a
// valid/ready input handshake and presents the index and value of the smallest one
// over a valid/ready output handshake, holding the result until it is consumed.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   clr   - synchronous clear; drops the partial frame and any pending result
//   bus   - stream bundle (slave side): in_valid/in_data/in_ready,
//           out_valid/out_index/out_min/out_ready
module min_of_four_stream #(
  parameter int unsigned WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  min_of_four_stream_if.slave   bus
);

  localparam logic [0:0] StCollect = 1'b0;
  localparam logic [0:0] StHold    = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] run_min_q, run_min_d;
  logic [1:0]       run_idx_q, run_idx_d;
  logic [WIDTH-1:0] out_min_q, out_min_d;
  logic [1:0]       out_idx_q, out_idx_d;
  logic             out_valid_q, out_valid_d;

  logic in_ready;
  logic in_accept;
  logic out_accept;
  logic take;

  // in_ready depends on the state register only, never on out_ready.
  assign in_ready   = (state_q == StCollect);
  assign in_accept  = bus.in_valid && in_ready;
  assign out_accept = out_valid_q && bus.out_ready;
  // Strict compare: on a tie the earlier position keeps the minimum.
  assign take       = (cnt_q == 2'd0) || (bus.in_data < run_min_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_min_d   = run_min_q;
    run_idx_d   = run_idx_q;
    out_min_d   = out_min_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;

    if (clr) begin
      state_d     = StCollect;
      cnt_d       = 2'd0;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StCollect: begin
          if (in_accept) begin
            if (take) begin
              run_min_d = bus.in_data;
              run_idx_d = cnt_q;
            end
            cnt_d = 2'(cnt_q + 2'd1);
            if (cnt_q == 2'd3) begin
              // Last sample of the frame: register the final result directly.
              out_min_d   = take ? bus.in_data : run_min_q;
              out_idx_d   = take ? cnt_q : run_idx_q;
              out_valid_d = 1'b1;
              state_d     = StHold;
            end
          end
        end
        StHold: begin
          if (out_accept) begin
            state_d     = StCollect;
            cnt_d       = 2'd0;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = StCollect;
          cnt_d       = 2'd0;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StCollect;
      cnt_q       <= 2'd0;
      run_min_q   <= '0;
      run_idx_q   <= 2'd0;
      out_min_q   <= '0;
      out_idx_q   <= 2'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_min_q   <= run_min_d;
      run_idx_q   <= run_idx_d;
      out_min_q   <= out_min_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_index = out_idx_q;
  assign bus.out_min   = out_min_q;

endmodule
